// File: rtl/tcp_tx_flow_sched.sv
// Round-robin flow scheduler: per-flow "needs TX" bitmap, one flow in flight.
// Optional macro TX_SCHED_PRIO_EN adds a priority bitmap fed by RX events.
module tcp_tx_flow_sched #(
  parameter int NUM_FLOWS = 64,
  parameter int FLOWID_W  = $clog2(NUM_FLOWS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                app_sched_set_val,
  input  logic [FLOWID_W-1:0] app_sched_set_flowid,
  output logic                app_sched_set_rdy,
  input  logic                rx_sched_set_val,
  input  logic [FLOWID_W-1:0] rx_sched_set_flowid,
  output logic                rx_sched_set_rdy,
  output logic                sched_tx_req_val,
  output logic [FLOWID_W-1:0] sched_tx_req_flowid,
  input  logic                tx_sched_req_rdy,
  input  logic                sched_tx_update_val,
  input  logic [FLOWID_W-1:0] sched_tx_update_flowid,
  input  logic                sched_tx_update_resched,
  output logic                sched_tx_update_rdy,
  output logic                sched_idle,
  output logic                sched_err
);

  // state    | meaning
  // PICK     | search bitmap from rr pointer, register winner
  // ISSUE    | grant valid, waiting for TX controller to accept
  // WAIT_UPD | grant accepted, waiting for completion update
  localparam logic [1:0] ST_PICK     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_UPD = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [NUM_FLOWS-1:0] bm_q, bm_d;
  logic [FLOWID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [FLOWID_W-1:0]  req_flowid_q, req_flowid_d;
  logic                 err_q, err_d;
  logic [FLOWID_W:0]    norm_hit;
  logic                 bitmaps_empty;

`ifdef TX_SCHED_PRIO_EN
  logic [NUM_FLOWS-1:0] prio_bm_q, prio_bm_d;
  logic [FLOWID_W-1:0]  prio_ptr_q, prio_ptr_d;
  logic [FLOWID_W:0]    prio_hit;
`endif

  // Returns {found, index} of the first set bit at or after ptr, wrapping.
  // Scanning from the far end lets the nearest hit overwrite the rest.
  function automatic logic [FLOWID_W:0] rr_search(input logic [NUM_FLOWS-1:0] bm,
                                                  input logic [FLOWID_W-1:0]  ptr);
    logic [FLOWID_W:0]   res;
    logic [FLOWID_W-1:0] idx;
    res = '0;
    for (int i = NUM_FLOWS - 1; i >= 0; i--) begin
      idx = ptr + FLOWID_W'(i);
      if (bm[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d      = state_q;
    bm_d         = bm_q;
    rr_ptr_d     = rr_ptr_q;
    req_flowid_d = req_flowid_q;
    err_d        = err_q;
    norm_hit     = rr_search(bm_q, rr_ptr_q);
`ifdef TX_SCHED_PRIO_EN
    prio_bm_d    = prio_bm_q;
    prio_ptr_d   = prio_ptr_q;
    prio_hit     = rr_search(prio_bm_q, prio_ptr_q);
`endif

    case (state_q)
      ST_PICK: begin
`ifdef TX_SCHED_PRIO_EN
        if (prio_hit[FLOWID_W]) begin
          req_flowid_d                     = prio_hit[FLOWID_W-1:0];
          bm_d[prio_hit[FLOWID_W-1:0]]      = 1'b0;
          prio_bm_d[prio_hit[FLOWID_W-1:0]] = 1'b0;
          prio_ptr_d                       = prio_hit[FLOWID_W-1:0] + FLOWID_W'(1);
          state_d                          = ST_ISSUE;
        end else if (norm_hit[FLOWID_W]) begin
          req_flowid_d                     = norm_hit[FLOWID_W-1:0];
          bm_d[norm_hit[FLOWID_W-1:0]]      = 1'b0;
          prio_bm_d[norm_hit[FLOWID_W-1:0]] = 1'b0;
          state_d                          = ST_ISSUE;
        end
`else
        if (norm_hit[FLOWID_W]) begin
          req_flowid_d                = norm_hit[FLOWID_W-1:0];
          bm_d[norm_hit[FLOWID_W-1:0]] = 1'b0;
          state_d                     = ST_ISSUE;
        end
`endif
      end
      ST_ISSUE: begin
        if (tx_sched_req_rdy) state_d = ST_WAIT_UPD;
      end
      ST_WAIT_UPD: begin
        if (sched_tx_update_val) begin
          if (sched_tx_update_resched) bm_d[sched_tx_update_flowid] = 1'b1;
          if (sched_tx_update_flowid != req_flowid_q) err_d = 1'b1;
          rr_ptr_d = req_flowid_q + FLOWID_W'(1);
          state_d  = ST_PICK;
        end
      end
      default: state_d = ST_PICK;
    endcase

    // New events are applied after the grant clear so a coincident set survives.
    if (app_sched_set_val) bm_d[app_sched_set_flowid] = 1'b1;
`ifdef TX_SCHED_PRIO_EN
    if (rx_sched_set_val) prio_bm_d[rx_sched_set_flowid] = 1'b1;
`else
    if (rx_sched_set_val) bm_d[rx_sched_set_flowid] = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_PICK;
      bm_q         <= '0;
      rr_ptr_q     <= '0;
      req_flowid_q <= '0;
      err_q        <= 1'b0;
`ifdef TX_SCHED_PRIO_EN
      prio_bm_q    <= '0;
      prio_ptr_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      bm_q         <= bm_d;
      rr_ptr_q     <= rr_ptr_d;
      req_flowid_q <= req_flowid_d;
      err_q        <= err_d;
`ifdef TX_SCHED_PRIO_EN
      prio_bm_q    <= prio_bm_d;
      prio_ptr_q   <= prio_ptr_d;
`endif
    end
  end

`ifdef TX_SCHED_PRIO_EN
  assign bitmaps_empty = (bm_q == '0) && (prio_bm_q == '0);
`else
  assign bitmaps_empty = (bm_q == '0);
`endif

  // Handshake outputs are gated by rst so they read inactive while reset is held.
  assign app_sched_set_rdy   = rst;
  assign rx_sched_set_rdy    = rst;
  assign sched_tx_req_val    = rst && (state_q == ST_ISSUE);
  assign sched_tx_req_flowid = req_flowid_q;
  assign sched_tx_update_rdy = rst && (state_q == ST_WAIT_UPD);
  assign sched_idle          = !rst || (bitmaps_empty && (state_q == ST_PICK));
  assign sched_err           = err_q;

endmodule
